rom_stream_reader: RTL
======================

// Module: rom_stream_reader
// PURPOSE
//   Read-side master for the 16x16 synchronous ROM. On start, it issues a burst of
//   sequential reads (rom_en/rom_add) from a base address and captures rom_data.
//   It presents each word on a valid/ready stream output, buffered so downstream
//   backpressure never loses an in-flight word. Sits between the ROM and any consumer.
// PARAMETERS
//   AW     4   ROM address width (depth 2**AW words)
//   DW     16  ROM data width
//   DEPTH  2   output buffer entries (>= ROM read latency + 1; fixed latency 1)
// PORTS
//   clk        in   1      single clock, all logic on posedge
//   rst        in   1      synchronous, active-high reset
//   start      in   1      1-cycle pulse: begin burst (ignored while busy=1)
//   base_add   in   AW     first ROM address, sampled with start
//   count      in   AW+1   words to read, sampled with start; 0 = empty burst
//   rom_en     out  1      ROM read enable
//   rom_add    out  AW     ROM address
//   rom_data   in   DW     ROM read data, valid 1 clk after rom_en=1
//   out_data   out  DW     stream word
//   out_valid  out  1      out_data valid
//   out_ready  in   1      consumer accepts when out_valid & out_ready
//   busy       out  1      burst in progress (start..last word accepted)
//   done       out  1      1-cycle pulse after last word accepted
// BEHAVIOUR
//   - Reset (rst=1 at posedge): state IDLE, rom_en=0, rom_add=0, out_valid=0,
//     out_data=0, busy=0, done=0, buffer emptied, in-flight read discarded.
//   - FSM IDLE -> READ on start (count!=0); IDLE -> DONE on start with count==0.
//     READ -> DRAIN once count reads issued; DRAIN -> DONE when buffer empty and
//     no read in flight; DONE -> IDLE after one cycle (done=1 exactly in DONE).
//   - busy=1 in READ, DRAIN, DONE... no: busy=1 in READ and DRAIN only; busy rises the
//     cycle after start is sampled.
//   - Issue rule: rom_en=1 in READ iff (buffer occupancy + in-flight reads) < DEPTH,
//     computed with the same-cycle pop counted as freeing a slot.
//   - rom_add = base_add for the first read, then +1 per issued read, wraps modulo
//     2**AW (base 4'hF, count 3 -> F,0,1).
//   - rom_data captured into buffer the cycle after the rom_en=1 edge (latency 1).
//   - Ordering strictly preserved; each word presented once, held stable with
//     out_valid=1 until accepted (no drop, no duplicate).
//   - Simultaneous push and pop on a full buffer: both occur, occupancy unchanged.
//   - Min latency start -> first out_valid: 2 clk (issue, capture).
//     Full throughput 1 word/clk with out_ready held 1.
//   - count > 2**AW is legal: address keeps wrapping and words repeat.
//   - start while busy: ignored, no state change.
//   - rst mid-burst: returns to reset state next edge, no done pulse.
// STRUCTURE
//   - Shared package rom_pkg: AW/DW defaults, FSM state encoding
//     (ST_IDLE, ST_READ, ST_DRAIN, ST_DONE).
//   - One sub-module: rom_rd_fifo (DEPTH x DW synchronous FIFO, push/pop/full/empty/
//     count, sync active-high reset). Top holds FSM, address/remaining counters,
//     in-flight flag.
// TESTING (bench instantiates rom + rom_stream_reader; ROM word i = 16'h1000+i)
//   1. base 0, count 7, out_ready=1 -> words 1000..1006 on 7 consecutive cycles,
//      first at start+2, done 1 clk after last accept, busy low after.
//   2. base F, count 3 -> rom_add F,0,1; out_data 100F,1000,1001 (wrap).
//   3. base 2, count 5, out_ready toggling 1/0 each clk -> 1002..1006 in order,
//      no loss or repeat, rom_en stalls when buffer+in-flight = 2.
//   4. out_ready=0 for 10 clk after start -> exactly 2 words buffered, rom_en low,
//      out_data 1000 stable; release -> remaining words follow in order.
//   5. count 0 -> no rom_en, out_valid stays 0, done pulses 1 clk after start.
//   6. rst=1 mid-burst (after 3 words) -> next edge all outputs 0, no done; new
//      start base 8 count 2 -> 1008,1009.

Source files
------------

// File: rtl/rom_pkg.sv
// Shared definitions for the ROM stream reader: default geometry and the
// burst controller state encoding.
package rom_pkg;

  localparam int AW_DEF    = 4;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

endpackage

// File: rtl/rom_rd_fifo.sv
// Small synchronous FIFO that holds captured ROM words until the consumer takes them.
// A push and a pop in the same cycle are both honoured, including when full.
module rom_rd_fifo #(
  parameter int  DEPTH = 2,
  parameter int  DW    = 16,
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  output logic [DW-1:0] pop_data_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);
  assign count_d = count_q + CW'(do_push) - CW'(do_pop);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of the order the always blocks are evaluated.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      count_q <= count_d;
    end
  end

  // NOTE: the storage array is deliberately not reset; occupancy is tracked by
  // count_q, so stale contents are never observable and the array can map to RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == CW'(DEPTH));
  assign count_o    = count_q;
  assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/rom_stream_reader.sv
// Burst read master for a latency-1 synchronous ROM; streams the words out over
// valid/ready with a small buffer so backpressure never drops an in-flight read.
module rom_stream_reader
  import rom_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_add,
  input  logic [AW:0]   count,
  output logic          rom_en,
  output logic [AW-1:0] rom_add,
  input  logic [DW-1:0] rom_data,
  output logic [DW-1:0] out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy,
  output logic          done
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t        state_q, state_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [AW:0]   rem_q, rem_d;
  logic          inflight_q;

  logic [CW-1:0] fifo_count;
  logic          fifo_full, fifo_empty;
  logic          pop;
  logic [CW:0]   slots_used;

  rom_rd_fifo #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_data_i (rom_data),
    .pop_i       (pop),
    .pop_data_o  (out_data),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;

  // NOTE: every output of this block gets a default before the case statement,
  // so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    rom_en     = 1'b0;
    // A word leaving the buffer this cycle frees its slot for a new read.
    slots_used = {1'b0, fifo_count} + (CW + 1)'(inflight_q) - (CW + 1)'(pop);

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          addr_d  = base_add;
          rem_d   = count;
          state_d = (count == '0) ? ST_DONE : ST_READ;
        end
      end
      ST_READ: begin
        if ((!fifo_full || pop) && (slots_used < (CW + 1)'(DEPTH))) begin
          rom_en = 1'b1;
          addr_d = addr_q + 1'b1;
          rem_d  = rem_q - 1'b1;
          if (rem_q == (AW + 1)'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (fifo_empty && !inflight_q) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      rem_q      <= '0;
      inflight_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      inflight_q <= rom_en;
    end
  end

  assign rom_add = addr_q;
  assign busy    = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign done    = (state_q == ST_DONE);

endmodule
